// File: rtl/emif_avmm_mem_responder_if.sv
// Avalon-MM EMIF channel bundle between an AFU memory master and the RAM-backed responder.
interface emif_avmm_mem_responder_if #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 576,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int BYTEENABLE_WIDTH = 72
);
    logic [ADDR_WIDTH-1:0]       address;
    logic                        read;
    logic                        write;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [BYTEENABLE_WIDTH-1:0] byteenable;
    logic                        waitrequest;
    logic [DATA_WIDTH-1:0]       readdata;
    logic                        readdatavalid;

    modport master (
        output address, read, write, burstcount, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, burstcount, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/emif_avmm_mem_responder.sv
// Avalon-MM burst slave standing in for an EMIF channel: on-chip RAM backing store,
// zero-latency writes, one-beat-per-cycle burst reads, sticky protocol-violation flag.
module emif_avmm_mem_responder #(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 576,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int BYTEENABLE_WIDTH = 72,
    parameter int MEM_ADDR_WIDTH   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          mem_clk,
    output logic                          mem_rst_n,
    output logic                          protocol_err,
    emif_avmm_mem_responder_if.slave      bus
);
    localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t                       state, state_n;
    logic [MEM_ADDR_WIDTH-1:0]    wr_addr, wr_addr_n;
    logic [BURSTCOUNT_WIDTH-1:0]  wr_remaining, wr_remaining_n;
    logic [MEM_ADDR_WIDTH-1:0]    rd_addr, rd_addr_n;
    logic [BURSTCOUNT_WIDTH-1:0]  rd_remaining, rd_remaining_n;

    logic                         ram_we;
    logic [MEM_ADDR_WIDTH-1:0]    ram_waddr;
    logic                         rd_vld_p0;
    logic                         err_set;

    logic [DATA_WIDTH-1:0]        mem [MEM_DEPTH];

    logic [MEM_ADDR_WIDTH-1:0]    cmd_addr;
    logic                         bc_zero;
    logic                         bc_one;

    assign mem_clk  = clk;
    assign cmd_addr = bus.address[MEM_ADDR_WIDTH-1:0];
    assign bc_zero  = (bus.burstcount == '0);
    assign bc_one   = (bus.burstcount == BURSTCOUNT_WIDTH'(1));

    // Upper address bits alias onto the RAM and are deliberately dropped.
    generate
        if (ADDR_WIDTH > MEM_ADDR_WIDTH) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.address[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
        end
    endgenerate

    always_comb begin
        state_n        = state;
        wr_addr_n      = wr_addr;
        wr_remaining_n = wr_remaining;
        rd_addr_n      = rd_addr;
        rd_remaining_n = rd_remaining;
        ram_we         = 1'b0;
        ram_waddr      = wr_addr;
        rd_vld_p0      = 1'b0;
        err_set        = 1'b0;

        case (state)
            IDLE: begin
                if (!bus.waitrequest) begin
                    if (bus.write) begin
                        if (bus.read) begin
                            err_set = 1'b1;
                        end
                        if (bc_zero) begin
                            err_set = 1'b1;
                        end else begin
                            ram_we    = 1'b1;
                            ram_waddr = cmd_addr;
                            if (!bc_one) begin
                                wr_remaining_n = bus.burstcount - BURSTCOUNT_WIDTH'(1);
                                wr_addr_n      = cmd_addr + MEM_ADDR_WIDTH'(1);
                                state_n        = WR_BURST;
                            end
                        end
                    end else if (bus.read) begin
                        if (bc_zero) begin
                            err_set = 1'b1;
                        end else begin
                            rd_addr_n      = cmd_addr;
                            rd_remaining_n = bus.burstcount;
                            state_n        = RD_BURST;
                        end
                    end
                end
            end

            WR_BURST: begin
                if (bus.read && !bus.waitrequest) begin
                    err_set = 1'b1;
                end
                if (bus.write && !bus.waitrequest) begin
                    ram_we         = 1'b1;
                    ram_waddr      = wr_addr;
                    wr_addr_n      = wr_addr + MEM_ADDR_WIDTH'(1);
                    wr_remaining_n = wr_remaining - BURSTCOUNT_WIDTH'(1);
                    if (wr_remaining == BURSTCOUNT_WIDTH'(1)) begin
                        state_n = IDLE;
                    end
                end
            end

            RD_BURST: begin
                rd_vld_p0      = 1'b1;
                rd_addr_n      = rd_addr + MEM_ADDR_WIDTH'(1);
                rd_remaining_n = rd_remaining - BURSTCOUNT_WIDTH'(1);
                if (rd_remaining == BURSTCOUNT_WIDTH'(1)) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        mem_rst_n <= ~rst;
        if (rst) begin
            state             <= IDLE;
            wr_addr           <= '0;
            wr_remaining      <= '0;
            rd_addr           <= '0;
            rd_remaining      <= '0;
            bus.waitrequest   <= 1'b1;
            bus.readdatavalid <= 1'b0;
            bus.readdata      <= '0;
            protocol_err      <= 1'b0;
        end else begin
            state             <= state_n;
            wr_addr           <= wr_addr_n;
            wr_remaining      <= wr_remaining_n;
            rd_addr           <= rd_addr_n;
            rd_remaining      <= rd_remaining_n;
            // Back-pressure only while a read burst is streaming out of the RAM.
            bus.waitrequest   <= (state_n == RD_BURST);
            bus.readdatavalid <= rd_vld_p0;
            if (rd_vld_p0) begin
                bus.readdata <= mem[rd_addr];
            end
            protocol_err      <= protocol_err | err_set;
        end
    end

    // RAM contents survive rst; writes are merely suppressed while it is asserted.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            for (int b = 0; b < BYTEENABLE_WIDTH; b++) begin
                if (bus.byteenable[b]) begin
                    mem[ram_waddr][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_emif_avmm_mem_responder.sv
// Scoreboard bench for emif_avmm_mem_responder: a shadow RAM predicts every read beat
// and the cycle it must appear on.
module tb_emif_avmm_mem_responder;
    localparam int AW  = 27;
    localparam int DW  = 576;
    localparam int BW  = 7;
    localparam int BEW = 72;
    localparam int MAW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clk;
    logic mem_rst_n;
    logic protocol_err;

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int rdv_count = 0;

    logic [DW-1:0] model [0:(1<<MAW)-1];
    logic [DW-1:0] exp_data_q [$];
    int            exp_cyc_q  [$];
    logic [DW-1:0] mon_d;
    int            mon_c;

    emif_avmm_mem_responder_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW), .BYTEENABLE_WIDTH(BEW)
    ) bus ();

    emif_avmm_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW),
        .BYTEENABLE_WIDTH(BEW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_clk(mem_clk),
        .mem_rst_n(mem_rst_n),
        .protocol_err(protocol_err),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        for (int b = 0; b < BEW; b++)
            if (be[b]) model[a % (1<<MAW)][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic wait_ready(input string what);
        int n = 0;
        while (bus.waitrequest !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout waitrequest still high after %0d cycles", what, n);
        end
    endtask

    task automatic write_burst(input int addr, input int bc, input logic [BEW-1:0] be,
                               input bit gaps, input logic [DW-1:0] beats [$]);
        for (int i = 0; i < bc; i++) begin
            bus.write      = 1'b1;
            bus.writedata  = beats[i];
            bus.byteenable = be;
            if (i == 0) begin
                bus.address    = AW'(addr);
                bus.burstcount = BW'(bc);
            end
            wait_ready("write");
            step();
            model_write(addr + i, beats[i], be);
            bus.write = 1'b0;
            if (gaps) step();
        end
    endtask

    task automatic read_cmd(input int addr, input int bc);
        int t;
        bus.read       = 1'b1;
        bus.address    = AW'(addr);
        bus.burstcount = BW'(bc);
        wait_ready("read");
        t = cyc;
        step();
        bus.read = 1'b0;
        for (int i = 0; i < bc; i++) begin
            exp_data_q.push_back(model[(addr + i) % (1<<MAW)]);
            exp_cyc_q.push_back(t + 2 + i);
        end
    endtask

    task automatic drain(input string what);
        int n = 0;
        while (exp_data_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        repeat (3) step();
        checks++;
        if (exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain outstanding beats %0d required 0", what, exp_data_q.size());
            exp_data_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.waitrequest !== 1'b1 || bus.readdatavalid !== 1'b0 || bus.readdata !== '0 ||
            protocol_err !== 1'b0 || mem_rst_n !== 1'b0 || mem_clk !== 1'b1) begin
            errors++;
            $display("FAIL reset_values wr=%b rdv=%b rdata_zero=%b err=%b mrst_n=%b mclk=%b required 1 0 1 0 0 1",
                     bus.waitrequest, bus.readdatavalid, (bus.readdata == '0), protocol_err, mem_rst_n, mem_clk);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.waitrequest !== 1'b0 || mem_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release wr=%b mrst_n=%b required 0 1", bus.waitrequest, mem_rst_n);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] beats [$];
        beats.push_back(rand_word());
        write_burst(5, 1, '1, 1'b0, beats);
        read_cmd(5, 1);
        drain("single");
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL single_protocol_err got %b required 0", protocol_err);
        end
    endtask

    task automatic test_wrap_burst();
        logic [DW-1:0] beats [$];
        for (int i = 0; i < 4; i++) beats.push_back(rand_word());
        write_burst(10'h3FE, 4, '1, 1'b1, beats);
        checks++;
        if (bus.waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL wrap_wr_waitrequest got %b required 0", bus.waitrequest);
        end
        read_cmd(10'h3FE, 4);
        drain("wrap_burst");
        read_cmd(27'h400, 1);
        drain("alias_word0");
    endtask

    task automatic test_partial();
        logic [DW-1:0] beats [$];
        logic [DW-1:0] expv;
        beats.push_back('1);
        write_burst(10'h10, 1, '1, 1'b0, beats);
        beats.delete();
        beats.push_back('0);
        write_burst(10'h10, 1, 72'h1, 1'b0, beats);
        expv      = '1;
        expv[7:0] = 8'h00;
        bus.read = 1'b1; bus.address = AW'(10'h10); bus.burstcount = BW'(1);
        wait_ready("partial");
        exp_data_q.push_back(expv);
        exp_cyc_q.push_back(cyc + 2);
        step();
        bus.read = 1'b0;
        drain("partial");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] beats [$];
        int t, n, base;
        for (int i = 0; i < 64; i++) beats.push_back(rand_word());
        write_burst(10'h100, 64, '1, 1'b0, beats);
        base = rdv_count;
        bus.read = 1'b1; bus.address = AW'(10'h100); bus.burstcount = BW'(64);
        wait_ready("b2b_first");
        t = cyc;
        for (int i = 0; i < 64; i++) begin
            exp_data_q.push_back(model[10'h100 + i]);
            exp_cyc_q.push_back(t + 2 + i);
        end
        step();
        bus.address = AW'(10'h120); bus.burstcount = BW'(2);
        n = 0;
        while (bus.waitrequest === 1'b1 && n < 200) begin
            n++;
            step();
        end
        checks++;
        if (n != 64 || cyc != t + 65) begin
            errors++;
            $display("FAIL b2b_waitrequest high=%0d cycles accept_at=%0d required 64 cycles accept_at=%0d",
                     n, cyc - t, 65);
        end
        for (int i = 0; i < 2; i++) begin
            exp_data_q.push_back(model[10'h120 + i]);
            exp_cyc_q.push_back(cyc + 2 + i);
        end
        step();
        bus.read = 1'b0;
        drain("b2b");
        checks++;
        if (rdv_count - base != 66) begin
            errors++;
            $display("FAIL b2b_pulses got %0d required 66", rdv_count - base);
        end
    endtask

    task automatic test_protocol_errors();
        logic [DW-1:0] e;
        logic [DW-1:0] beats [$];
        int base;
        e = rand_word();
        base = rdv_count;
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL err_before got %b required 0", protocol_err);
        end
        bus.read = 1'b1; bus.write = 1'b1; bus.address = AW'(10'h20);
        bus.burstcount = BW'(1); bus.writedata = e; bus.byteenable = '1;
        wait_ready("rw_both");
        step();
        bus.read = 1'b0; bus.write = 1'b0;
        model_write(10'h20, e, '1);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL err_rw_both got %b required 1", protocol_err);
        end
        bus.read = 1'b1; bus.address = AW'(10'h20); bus.burstcount = '0;
        step();
        bus.read = 1'b0;
        checks++;
        if (bus.waitrequest !== 1'b0 || protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL err_bc0_read wr=%b err=%b required 0 1", bus.waitrequest, protocol_err);
        end
        bus.write = 1'b1; bus.burstcount = '0; bus.writedata = ~e;
        step();
        bus.write = 1'b0;
        repeat (4) step();
        checks++;
        if (rdv_count != base) begin
            errors++;
            $display("FAIL err_dropped_reads pulses=%0d required 0", rdv_count - base);
        end
        read_cmd(10'h20, 1);
        drain("err_data");
        beats.push_back(rand_word());
        write_burst(10'h21, 1, '1, 1'b0, beats);
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b required 1", protocol_err);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] beats [$];
        int t, base;
        for (int i = 0; i < 8; i++) beats.push_back(rand_word());
        write_burst(10'h40, 8, '1, 1'b0, beats);
        base = rdv_count;
        bus.read = 1'b1; bus.address = AW'(10'h40); bus.burstcount = BW'(8);
        wait_ready("rst_read");
        t = cyc;
        for (int i = 0; i < 3; i++) begin
            exp_data_q.push_back(model[10'h40 + i]);
            exp_cyc_q.push_back(t + 2 + i);
        end
        step();
        bus.read = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.readdatavalid !== 1'b0 || bus.waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_read rdv=%b wr=%b required 0 1", bus.readdatavalid, bus.waitrequest);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.waitrequest !== 1'b0 || protocol_err !== 1'b0 || rdv_count - base != 3) begin
            errors++;
            $display("FAIL rst_release wr=%b err=%b pulses=%0d required 0 0 3",
                     bus.waitrequest, protocol_err, rdv_count - base);
        end
        read_cmd(10'h40, 8);
        drain("rst_retained");
        read_cmd(5, 1);
        drain("rst_retained_single");
    endtask

    initial begin
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.burstcount = '0; bus.writedata = '0; bus.byteenable = '0;
        fork
            forever begin
                @(negedge clk);
                if (bus.readdatavalid === 1'b1) begin
                    rdv_count++;
                    checks++;
                    if (exp_data_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_readdatavalid cycle=%0d", cyc);
                    end else begin
                        mon_d = exp_data_q.pop_front();
                        mon_c = exp_cyc_q.pop_front();
                        if (bus.readdata !== mon_d || cyc != mon_c) begin
                            errors++;
                            $display("FAIL read_beat cycle=%0d data=%h required cycle=%0d data=%h",
                                     cyc, bus.readdata, mon_c, mon_d);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_single();
        test_wrap_burst();
        test_partial();
        test_back_to_back();
        test_protocol_errors();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end
endmodule
